// File: rtl/job_descriptor_fetcher.sv
// job_descriptor_fetcher
// Walks a linked list of 16-byte job descriptors in memory over an AXI4 read
// port. For each descriptor it fetches one 4-beat burst, then requests a kernel
// slot from the global register block and hands the descriptor to the granted
// kernel. The list ends at the descriptor whose word0[0] (last) bit is set.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   manager_start         level run enable; a rising edge starts a list walk
//   init_addr             first descriptor address (low nibble forced to 0)
//   new_job / job_done    at least one kernel free / all kernels idle
//   job_start             one-cycle slot request to the global register block
//   kernel_start          one-hot grant, arrives the cycle after job_start
//   m_axi_ar* / m_axi_r*  AXI4 read address / read data channels
//   desc_valid            one-cycle strobe carrying a descriptor to a kernel
//   desc_kernel_sel       one-hot target kernel (held between strobes)
//   desc_data             {word3, word2, word1, word0} (held between strobes)
//   mgr_idle/done/error   status flags
//   jobs_dispatched       saturating count of dispatched descriptors
`timescale 1ns/1ps
module job_descriptor_fetcher #(
  parameter int         KERNEL_NUM = 8,
  parameter logic [7:0] DESC_MAGIC = 8'hD5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  manager_start,
  input  logic [63:0]           init_addr,
  input  logic                  new_job,
  input  logic                  job_done,
  output logic                  job_start,
  input  logic [KERNEL_NUM-1:0] kernel_start,
  output logic [63:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  desc_valid,
  output logic [KERNEL_NUM-1:0] desc_kernel_sel,
  output logic [127:0]          desc_data,
  output logic                  mgr_idle,
  output logic                  mgr_done,
  output logic                  mgr_error,
  output logic [31:0]           jobs_dispatched
);

  typedef enum logic [3:0] {
    IDLE, FETCH_AR, FETCH_R, WAIT_SLOT, START, DISPATCH, DRAIN, DONE, ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic                    start_prev_q;
  logic [63:0]             cur_addr_q;
  logic [3:0][31:0]        desc_buf_q;
  logic [2:0]              beat_cnt_q;
  logic                    err_q;
  logic                    abort_q;
  logic [31:0]             jobs_q;
  logic [KERNEL_NUM-1:0]   sel_q;
  logic [127:0]            data_q;

  logic        start_rise;
  logic        abort_now;
  logic        beat_err;
  logic        burst_err;
  logic        grant;
  logic        desc_last;
  logic [63:0] init_aligned;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign init_aligned = init_addr & ~64'hF;
  assign start_rise   = manager_start & ~start_prev_q;
  // An abort seen at any point of a fetch or a start/dispatch pair is remembered
  // so the block can finish the bus transaction first and then return to IDLE.
  assign abort_now    = abort_q | ~manager_start;
  assign grant        = |kernel_start;
  assign desc_last    = desc_buf_q[0][0];

  // Per-beat protocol and content checks; beats past the fourth only matter
  // for their rlast/rresp since their data is discarded.
  assign beat_err = (m_axi_rresp != 2'b00)
                  | ((beat_cnt_q == 3'd0) && (m_axi_rdata[31:24] != DESC_MAGIC))
                  | (m_axi_rlast && (beat_cnt_q != 3'd3))
                  | ((beat_cnt_q == 3'd3) && !m_axi_rlast);
  assign burst_err = err_q | beat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    m_axi_arvalid   = 1'b0;
    m_axi_arlen     = 8'd0;
    m_axi_rready    = 1'b0;
    job_start       = 1'b0;
    desc_valid      = 1'b0;
    desc_kernel_sel = sel_q;
    desc_data       = data_q;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = FETCH_AR;
      end
      FETCH_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_arlen   = 8'd3;
        if (m_axi_arready) state_d = FETCH_R;
      end
      FETCH_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) begin
          if (abort_now)      state_d = IDLE;
          else if (burst_err) state_d = ERROR;
          else                state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (!manager_start) state_d = IDLE;
        else if (new_job)   state_d = START;
      end
      START: begin
        job_start = 1'b1;
        state_d   = DISPATCH;
      end
      DISPATCH: begin
        if (grant) begin
          desc_valid      = 1'b1;
          desc_kernel_sel = kernel_start;
          desc_data       = desc_buf_q;
        end
        if (abort_now)      state_d = IDLE;
        else if (!grant)    state_d = WAIT_SLOT;
        else if (desc_last) state_d = DRAIN;
        else                state_d = FETCH_AR;
      end
      DRAIN: begin
        if (!manager_start) state_d = IDLE;
        else if (job_done)  state_d = DONE;
      end
      DONE: begin
        if (!manager_start) state_d = IDLE;
      end
      ERROR: begin
        if (!manager_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b1;
      cur_addr_q   <= '0;
      desc_buf_q   <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      jobs_q       <= '0;
      sel_q        <= '0;
      data_q       <= '0;
    end else begin
      start_prev_q <= manager_start;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (start_rise) begin
            cur_addr_q <= init_aligned;
            jobs_q     <= '0;
          end
        end
        FETCH_AR: begin
          if (!manager_start) abort_q <= 1'b1;
          if (m_axi_arready) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
          end
        end
        FETCH_R: begin
          if (!manager_start) abort_q <= 1'b1;
          if (m_axi_rvalid) begin
            // Count saturates at 4 so surplus beats are consumed but not stored.
            if (!beat_cnt_q[2]) begin
              desc_buf_q[beat_cnt_q[1:0]] <= m_axi_rdata;
              beat_cnt_q                  <= beat_cnt_q + 3'd1;
            end
            err_q <= burst_err;
          end
        end
        START: begin
          if (!manager_start) abort_q <= 1'b1;
        end
        DISPATCH: begin
          if (grant) begin
            jobs_q <= sat_inc(jobs_q);
            sel_q  <= kernel_start;
            data_q <= desc_buf_q;
            if (!desc_last) cur_addr_q <= cur_addr_q + 64'd16;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_araddr    = cur_addr_q;
  assign mgr_idle        = (state_q == IDLE);
  assign mgr_done        = (state_q == DONE);
  assign mgr_error       = (state_q == ERROR);
  assign jobs_dispatched = jobs_q;

endmodule

// File: tb/tb_job_descriptor_fetcher.sv
// Testbench for job_descriptor_fetcher: AXI read slave backed by a descriptor
// memory, a global-register-block grant model, and a scoreboard that checks
// every AR request and every descriptor dispatch against a list-walk model.
`timescale 1ns/1ps
module tb_job_descriptor_fetcher;
  localparam int         KN    = 8;
  localparam logic [7:0] MAGIC = 8'hD5;

  logic          clk, rst_n, manager_start, new_job, job_done, job_start;
  logic [63:0]   init_addr;
  logic [KN-1:0] kernel_start;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_arvalid, m_axi_arready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic          desc_valid;
  logic [KN-1:0] desc_kernel_sel;
  logic [127:0]  desc_data;
  logic          mgr_idle, mgr_done, mgr_error;
  logic [31:0]   jobs_dispatched;

  job_descriptor_fetcher #(.KERNEL_NUM(KN), .DESC_MAGIC(MAGIC)) dut (
    .clk(clk), .rst_n(rst_n), .manager_start(manager_start), .init_addr(init_addr),
    .new_job(new_job), .job_done(job_done), .job_start(job_start),
    .kernel_start(kernel_start),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .desc_valid(desc_valid), .desc_kernel_sel(desc_kernel_sel), .desc_data(desc_data),
    .mgr_idle(mgr_idle), .mgr_done(mgr_done), .mgr_error(mgr_error),
    .jobs_dispatched(jobs_dispatched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KN-1:0] sel;
    logic [127:0]  data;
  } exp_t;

  exp_t          exp_desc[$];
  logic [63:0]   exp_ar[$];
  logic [KN-1:0] grant_q[$];
  logic [127:0]  mem [logic [63:0]];
  logic [63:0]   model_addr;

  int tests, fails;
  int n_ar, n_r, n_desc, n_js, n_ar_wait, n_zero;
  int b_ar, b_desc, b_js, b_zero;
  int ar_delay_min, ar_delay_max, gap_pct, err_beat, zero_pct;
  bit nj_rand;
  logic nj_level;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rd_desc(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // AXI read slave: random AR latency, random R gaps, optional rresp fault.
  initial begin
    bit          pending, ar_hs, r_hs, last_s;
    int          beat, wait_cnt, cur_delay;
    logic [63:0] baddr, addr_s;
    logic [127:0] d;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    pending = 0; beat = 0; wait_cnt = 0; cur_delay = 0; baddr = '0;
    forever begin
      @(negedge clk);
      ar_hs  = m_axi_arvalid && m_axi_arready;
      r_hs   = m_axi_rvalid && m_axi_rready;
      last_s = m_axi_rlast;
      addr_s = m_axi_araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending = 0; wait_cnt = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        continue;
      end
      if (ar_hs) begin
        pending = 1; beat = 0; baddr = addr_s; wait_cnt = 0;
        m_axi_arready = 1'b0;
        cur_delay = $urandom_range(ar_delay_max, ar_delay_min);
      end else if (m_axi_arvalid && !pending) begin
        if (wait_cnt == 0) cur_delay = $urandom_range(ar_delay_max, ar_delay_min);
        m_axi_arready = (wait_cnt >= cur_delay);
        wait_cnt++;
      end
      if (r_hs) begin
        beat++;
        if (last_s) pending = 0;
      end
      if (pending && !(ar_hs && 0)) begin
        if ($urandom_range(99, 0) < gap_pct) begin
          m_axi_rvalid = 1'b0;
        end else begin
          d = rd_desc(baddr);
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = d[beat*32 +: 32];
          m_axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (beat == 3);
        end
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end
    end
  end

  // Global register block: registers a grant the cycle after job_start.
  // A nonzero grant is the moment the scoreboard learns which descriptor goes where.
  initial begin
    bit            js;
    logic [KN-1:0] g;
    exp_t          e;
    kernel_start = '0;
    forever begin
      @(negedge clk);
      js = job_start;
      @(posedge clk);
      #1;
      if (js && rst_n) begin
        if (grant_q.size() != 0)                    g = grant_q.pop_front();
        else if ($urandom_range(99, 0) < zero_pct) g = '0;
        else                                         g = KN'(1) << $urandom_range(KN-1, 0);
        kernel_start = g;
        if (g != '0) begin
          e.sel  = g;
          e.data = rd_desc(model_addr);
          exp_desc.push_back(e);
          model_addr = model_addr + 64'd16;
        end else begin
          n_zero++;
        end
      end else begin
        kernel_start = '0;
      end
    end
  end

  initial begin
    new_job = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      new_job = nj_rand ? 1'($urandom_range(1, 0)) : nj_level;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic          prev_nj, prev_ar_wait;
    logic [63:0]   prev_addr;
    logic [KN-1:0] last_sel;
    logic [127:0]  last_data;
    exp_t          e;
    logic [63:0]   ea;
    prev_nj = 1'b0; prev_ar_wait = 1'b0; prev_addr = '0; last_sel = '0; last_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ar_wait = 1'b0; prev_nj = new_job; last_sel = '0; last_data = '0;
        continue;
      end
      if (desc_valid) begin
        n_desc++;
        check("desc_with_job_start", job_start, 1'b0);
        check("desc_expected_pending", exp_desc.size() != 0, 1'b1);
        if (exp_desc.size() != 0) begin
          e = exp_desc.pop_front();
          check("desc_sel", desc_kernel_sel, e.sel);
          check("desc_data", desc_data, e.data);
        end
        last_sel = desc_kernel_sel; last_data = desc_data;
      end else begin
        check("hold_sel", desc_kernel_sel, last_sel);
        check("hold_data", desc_data, last_data);
      end
      if (job_start) begin
        n_js++;
        check("job_start_after_new_job", prev_nj, 1'b1);
      end
      if (prev_ar_wait) begin
        check("arvalid_held", m_axi_arvalid, 1'b1);
        check("araddr_stable", m_axi_araddr, prev_addr);
      end
      if (m_axi_arvalid && !m_axi_arready) n_ar_wait++;
      if (m_axi_arvalid && m_axi_arready) begin
        n_ar++;
        check("arlen", m_axi_arlen, 8'd3);
        check("ar_expected_pending", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) begin
          ea = exp_ar.pop_front();
          check("araddr", m_axi_araddr, ea);
        end
      end
      if (m_axi_rvalid && m_axi_rready) n_r++;
      if (mgr_error) check("no_ar_in_error", m_axi_arvalid, 1'b0);
      prev_ar_wait = m_axi_arvalid && !m_axi_arready;
      prev_addr    = m_axi_araddr;
      prev_nj      = new_job;
    end
  end

  task automatic do_reset(input logic ms);
    rst_n = 1'b0; manager_start = ms; job_done = 1'b0; init_addr = '0;
    repeat (3) step();
    check("rst_mgr_idle", mgr_idle, 1'b1);
    check("rst_mgr_done", mgr_done, 1'b0);
    check("rst_mgr_error", mgr_error, 1'b0);
    check("rst_job_start", job_start, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", m_axi_arlen, 8'd0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_desc_valid", desc_valid, 1'b0);
    check("rst_desc_sel", desc_kernel_sel, '0);
    check("rst_desc_data", desc_data, '0);
    check("rst_jobs", jobs_dispatched, 32'd0);
    exp_desc.delete(); exp_ar.delete(); grant_q.delete(); mem.delete();
    n_ar = 0; n_r = 0; n_desc = 0; n_js = 0; n_ar_wait = 0; n_zero = 0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic build_list(input logic [63:0] base, input int n, input int push_n);
    logic [31:0]  r;
    logic [127:0] d;
    logic [63:0]  a;
    for (int i = 0; i < n; i++) begin
      a = base + 64'(16 * i);
      r = $urandom;
      d = {$urandom, $urandom, $urandom, MAGIC, r[22:0], (i == n - 1) ? 1'b1 : 1'b0};
      mem[a] = d;
      if (i < push_n) exp_ar.push_back(a);
    end
  endtask

  task automatic start_run(input logic [63:0] init);
    init_addr  = init;
    model_addr = init & ~64'hF;
    b_ar = n_ar; b_desc = n_desc; b_js = n_js; b_zero = n_zero;
    manager_start = 1'b0;
    step();
    manager_start = 1'b1;
    step();
  endtask

  task automatic finish_run(input int n);
    int c;
    c = 0;
    while ((n_desc - b_desc) < n && c < 3000) begin step(); c++; end
    check("desc_count", n_desc - b_desc, n);
    repeat (5) step();
    check("done_waits_job_done", mgr_done, 1'b0);
    job_done = 1'b1;
    c = 0;
    while (!mgr_done && c < 20) begin step(); c++; end
    check("mgr_done", mgr_done, 1'b1);
    check("jobs_dispatched", jobs_dispatched, n);
    check("ar_count", n_ar - b_ar, n);
    check("job_start_count", n_js - b_js, n + (n_zero - b_zero));
    check("exp_ar_drained", exp_ar.size(), 0);
    check("exp_desc_drained", exp_desc.size(), 0);
    job_done = 1'b0;
    manager_start = 1'b0;
    step();
    check("back_to_idle", mgr_idle, 1'b1);
    check("done_cleared", mgr_done, 1'b0);
  endtask

  task automatic error_run(input logic [63:0] base);
    int c;
    start_run(base);
    c = 0;
    while (!mgr_error && c < 200) begin step(); c++; end
    check("mgr_error_set", mgr_error, 1'b1);
    repeat (10) step();
    check("err_ar_count", n_ar - b_ar, 1);
    check("err_no_job_start", n_js - b_js, 0);
    check("err_no_desc", n_desc - b_desc, 0);
    manager_start = 1'b0;
    step();
    check("err_to_idle", mgr_idle, 1'b1);
    check("err_cleared", mgr_error, 1'b0);
  endtask

  initial begin
    int          c, n;
    logic [63:0] base;
    logic [127:0] d;
    tests = 0; fails = 0;
    ar_delay_min = 0; ar_delay_max = 0; gap_pct = 0; err_beat = -1; zero_pct = 0;
    nj_rand = 0; nj_level = 1'b1;
    n_ar = 0; n_r = 0; n_desc = 0; n_js = 0; n_ar_wait = 0; n_zero = 0;
    rst_n = 1'b0; manager_start = 1'b0; job_done = 1'b0; init_addr = '0; model_addr = '0;

    // manager_start high straight out of reset is not a rising edge
    do_reset(1'b1);
    repeat (10) step();
    check("no_edge_stays_idle", mgr_idle, 1'b1);
    check("no_edge_no_ar", n_ar, 0);

    // single job, unaligned init address, fixed grant 0x80
    do_reset(1'b0);
    build_list(64'h1000_0000, 1, 1);
    d = mem[64'h1000_0000]; d[31:0] = 32'hD500_0001; mem[64'h1000_0000] = d;
    grant_q.push_back(8'h80);
    start_run(64'h1000_0008);
    finish_run(1);

    // three-descriptor list with random readiness, gaps and grants
    do_reset(1'b0);
    nj_rand = 1; gap_pct = 30; ar_delay_min = 0; ar_delay_max = 3;
    build_list(64'h0000_0000_2000_0100, 3, 3);
    start_run(64'h0000_0000_2000_0100);
    finish_run(3);

    // random lists back to back (jobs_dispatched restarts each run), random zero grants
    zero_pct = 25;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(5, 1);
      base = {$urandom, $urandom} & ~64'hF;
      build_list(base, n, n);
      start_run(base | 64'($urandom_range(15, 0)));
      finish_run(n);
    end
    zero_pct = 0;

    // zero grant: retried with the same descriptor
    do_reset(1'b0);
    build_list(64'h0000_0040_0000_0000, 1, 1);
    grant_q.push_back(8'h00);
    grant_q.push_back(8'h04);
    start_run(64'h0000_0040_0000_0000);
    finish_run(1);
    check("retry_job_starts", n_js - b_js, 2);

    // rresp error on beat 1
    do_reset(1'b0);
    nj_rand = 0; gap_pct = 0; ar_delay_min = 0; ar_delay_max = 0;
    build_list(64'h3000, 2, 1);
    err_beat = 1;
    error_run(64'h3000);
    err_beat = -1;

    // bad magic in word0
    do_reset(1'b0);
    build_list(64'h4000, 2, 1);
    d = mem[64'h4000]; d[31:0] = 32'h1200_0000; mem[64'h4000] = d;
    error_run(64'h4000);

    // arready low five cycles, then abort during the R burst
    do_reset(1'b0);
    ar_delay_min = 5; ar_delay_max = 5; gap_pct = 50;
    build_list(64'h5000, 2, 1);
    start_run(64'h5000);
    c = 0;
    while (n_r < 1 && c < 100) begin step(); c++; end
    check("abort_burst_started", n_r >= 1, 1'b1);
    manager_start = 1'b0;
    c = 0;
    while (!mgr_idle && c < 100) begin step(); c++; end
    check("abort_idle", mgr_idle, 1'b1);
    check("abort_all_beats", n_r, 4);
    check("ar_wait_cycles", n_ar_wait, 5);
    repeat (10) step();
    check("abort_no_job_start", n_js, 0);
    check("abort_single_ar", n_ar, 1);
    check("abort_no_desc", n_desc, 0);
    ar_delay_min = 0; ar_delay_max = 0; gap_pct = 0;

    // address wrap at the top of the 64-bit space
    do_reset(1'b0);
    build_list(64'hFFFF_FFFF_FFFF_FFF0, 2, 2);
    start_run(64'hFFFF_FFFF_FFFF_FFF0);
    finish_run(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
